nec_ir_tx: RTL and testbench

NEC_IR_TX -- requirements
Module: nec_ir_tx

---
 rtl/nec_ir_tx_pkg.sv | 36 +++
 rtl/nec_carrier_gen.sv | 39 +++
 rtl/nec_ir_tx.sv | 158 +++++++++++++++
 tb/tb_nec_ir_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nec_ir_tx_pkg.sv
// Shared NEC IR transmitter definitions: FSM states, frame unit counts and
// clock-derived timing helpers (unit tick T and 38 kHz carrier period).
package nec_ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    RPT_SPACE
  } nec_state_e;

  localparam int unsigned LEAD_UNITS       = 16;
  localparam int unsigned LEAD_SP_UNITS    = 8;
  localparam int unsigned RPT_SP_UNITS     = 4;
  localparam int unsigned ONE_SP_UNITS     = 3;
  localparam int unsigned BIT_UNITS        = 1;
  localparam int unsigned CARRIER_KHZ      = 38;
  localparam int unsigned CARRIER_DUTY_DIV = 3;

  // 562.5 us expressed in system clocks, truncated
  function automatic int unsigned unit_clocks(input int unsigned mhz);
    return (mhz * 1125) / 2;
  endfunction

  function automatic int unsigned carrier_period(input int unsigned mhz);
    return (mhz * 1000) / CARRIER_KHZ;
  endfunction

  function automatic logic is_mark(input nec_state_e s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

endpackage

// File: rtl/nec_carrier_gen.sv
// 38 kHz carrier generator: free-running period counter while enabled, high for
// the first PERIOD/CARRIER_DUTY_DIV clocks, phase forced to zero by restart_i.
module nec_carrier_gen
  import nec_ir_pkg::*;
#(
  parameter int unsigned PERIOD = 52
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic restart_i,
  output logic carrier_o
);

  localparam int unsigned HIGH  = PERIOD / CARRIER_DUTY_DIV;
  localparam int unsigned CNT_W = $clog2(PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == CNT_W'(PERIOD - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carrier_o = enable_i && (cnt_q < CNT_W'(HIGH));

endmodule

// File: rtl/nec_ir_tx.sv
// NEC IR frame transmitter (full frame or repeat code). Define NEC_IR_TX_CARRIER_EN
// to modulate marks with a 38 kHz carrier; otherwise o_ir is the baseband envelope.
//
// state      | meaning
// IDLE       | ready for a request, o_ir low
// LEAD_MARK  | 16 T leader burst
// LEAD_SPACE | 8 T leader gap (full frame)
// BIT_MARK   | 1 T burst that opens every data bit
// BIT_SPACE  | 1 T ('0') or 3 T ('1') gap
// STOP_MARK  | 1 T trailing burst, o_done on its last cycle
// RPT_SPACE  | 4 T gap of a repeat code
module nec_ir_tx
  import nec_ir_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_MHZ = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  input  logic       i_repeat,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_cmd,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ir
);

  localparam int unsigned T       = unit_clocks(CLOCK_FREQ_MHZ);
  localparam int unsigned TIMER_W = $clog2(LEAD_UNITS * T);

  // Timer reload values are (duration - 1) so terminal count lands on the last cycle
  localparam logic [TIMER_W-1:0] LD_LEAD    = TIMER_W'(LEAD_UNITS * T - 1);
  localparam logic [TIMER_W-1:0] LD_LEAD_SP = TIMER_W'(LEAD_SP_UNITS * T - 1);
  localparam logic [TIMER_W-1:0] LD_RPT_SP  = TIMER_W'(RPT_SP_UNITS * T - 1);
  localparam logic [TIMER_W-1:0] LD_ONE_SP  = TIMER_W'(ONE_SP_UNITS * T - 1);
  localparam logic [TIMER_W-1:0] LD_BIT     = TIMER_W'(BIT_UNITS * T - 1);

  nec_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [4:0]         bit_q, bit_d;
  logic [31:0]        data_q, data_d;
  logic               rpt_q, rpt_d;
  logic               tc;
  logic               mark;

  assign tc = (timer_q == '0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    data_d  = data_q;
    rpt_d   = rpt_q;
    if (state_q != IDLE && !tc) begin
      timer_d = timer_q - 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = LEAD_MARK;
          timer_d = LD_LEAD;
          bit_d   = '0;
          rpt_d   = i_repeat;
          data_d  = {~i_cmd, i_cmd, ~i_addr, i_addr};
        end
      end
      LEAD_MARK: begin
        if (tc) begin
          state_d = rpt_q ? RPT_SPACE : LEAD_SPACE;
          timer_d = rpt_q ? LD_RPT_SP : LD_LEAD_SP;
        end
      end
      LEAD_SPACE: begin
        if (tc) begin
          state_d = BIT_MARK;
          timer_d = LD_BIT;
        end
      end
      BIT_MARK: begin
        if (tc) begin
          state_d = BIT_SPACE;
          timer_d = data_q[0] ? LD_ONE_SP : LD_BIT;
        end
      end
      BIT_SPACE: begin
        if (tc) begin
          timer_d = LD_BIT;
          if (bit_q == 5'd31) begin
            state_d = STOP_MARK;
          end else begin
            state_d = BIT_MARK;
            bit_d   = bit_q + 1'b1;
            data_d  = {1'b0, data_q[31:1]};
          end
        end
      end
      RPT_SPACE: begin
        if (tc) begin
          state_d = STOP_MARK;
          timer_d = LD_BIT;
        end
      end
      STOP_MARK: begin
        if (tc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      rpt_q   <= rpt_d;
    end
  end

  assign mark    = is_mark(state_q);
  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q != IDLE);
  assign o_done  = (state_q == STOP_MARK) && tc;

`ifdef NEC_IR_TX_CARRIER_EN
  localparam int unsigned P = carrier_period(CLOCK_FREQ_MHZ);

  logic carrier;
  logic restart;

  // Restart one cycle early so the first mark cycle sees phase zero (carrier high)
  assign restart = is_mark(state_d) && !mark;

  nec_carrier_gen #(
    .PERIOD(P)
  ) u_carrier (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable_i  (mark),
    .restart_i (restart),
    .carrier_o (carrier)
  );

  assign o_ir = carrier;
`else
  assign o_ir = mark;
`endif

endmodule

// File: tb/tb_nec_ir_tx.sv
// Directed bench for nec_ir_tx at 2 MHz (T = 1125 clocks, carrier period 52, high 17).
// Decodes mark/space run lengths from o_ir in baseband builds; checks carrier phase otherwise.
module tb_nec_ir_tx;

  localparam int FRAME_BUDGET = 140000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_valid;
  logic       i_repeat;
  logic [7:0] i_addr;
  logic [7:0] i_cmd;
  logic       o_ready;
  logic       o_busy;
  logic       o_done;
  logic       o_ir;

  int checks = 0;
  int errors = 0;
  int runs[$];

  typedef struct {
    logic        rpt;
    logic [7:0]  addr;
    logic [7:0]  cmd;
    int          exp_done;
    int          exp_space;
    logic [31:0] exp_bits;
  } vec_t;

  vec_t vecs[3];

  nec_ir_tx #(
    .CLOCK_FREQ_MHZ(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .i_repeat (i_repeat),
    .i_addr   (i_addr),
    .i_cmd    (i_cmd),
    .o_ready  (o_ready),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_ir     (o_ir)
  );

  always #5 clk = ~clk;

  initial begin
    #(10 * 500000);
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Issue one request, then scramble the inputs to prove they were captured.
  // Samples each cycle at negedge; n = 1 is the first cycle after acceptance.
  task automatic send_frame(input logic rpt, input logic [7:0] a, input logic [7:0] c,
                            output int done_at, output int inv_bad, output int car_bad);
    logic cur;
    int   len;
    @(negedge clk);
    i_valid = 1'b1; i_repeat = rpt; i_addr = a; i_cmd = c;
    @(negedge clk);
    i_valid = 1'b0; i_repeat = ~rpt; i_addr = ~a; i_cmd = ~c;
    runs.delete();
    cur = 1'b1; len = 0; done_at = -1; inv_bad = 0; car_bad = 0;
    for (int n = 1; n <= FRAME_BUDGET; n++) begin
      if (n > 1) @(negedge clk);
      if (o_busy === o_ready) inv_bad++;
`ifdef NEC_IR_TX_CARRIER_EN
      if (n <= 18000 && o_ir !== (((n - 1) % 52) < 17)) car_bad++;
      if (!rpt && n >= 27001 && n <= 28125 && o_ir !== (((n - 27001) % 52) < 17)) car_bad++;
`else
      if (o_ir === cur) len++;
      else begin
        runs.push_back(len);
        cur = o_ir;
        len = 1;
      end
`endif
      if (o_done === 1'b1) begin
        done_at = n;
        break;
      end
    end
    runs.push_back(len);
  endtask

  initial begin
    int          done_at, inv_bad, car_bad, shape_bad, quiet_bad, rdy_cnt;
    logic [31:0] bits;
    int          dq[$];

    vecs[0] = '{rpt: 1'b0, addr: 8'h00, cmd: 8'h00, exp_done: 136125, exp_space: 9000, exp_bits: 32'hFF00_FF00};
    vecs[1] = '{rpt: 1'b0, addr: 8'hA5, cmd: 8'h3C, exp_done: 136125, exp_space: 9000, exp_bits: 32'hC33C_5AA5};
    vecs[2] = '{rpt: 1'b1, addr: 8'h12, cmd: 8'h34, exp_done: 23625,  exp_space: 4500, exp_bits: 32'h0};

    // Reset with i_valid held high: must stay idle
    rst_n = 1'b0; i_valid = 1'b1; i_repeat = 1'b0; i_addr = 8'h55; i_cmd = 8'hAA;
    repeat (3) @(negedge clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ir", o_ir, 0);
    i_valid = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("idle_ready", o_ready, 1);
    chk("idle_ir", o_ir, 0);

    for (int i = 0; i < 3; i++) begin
      send_frame(vecs[i].rpt, vecs[i].addr, vecs[i].cmd, done_at, inv_bad, car_bad);
      chk($sformatf("v%0d_done_at", i), done_at, vecs[i].exp_done);
      chk($sformatf("v%0d_busy_inv", i), inv_bad, 0);
`ifdef NEC_IR_TX_CARRIER_EN
      chk($sformatf("v%0d_carrier", i), car_bad, 0);
`else
      chk($sformatf("v%0d_lead_mark", i), runs[0], 18000);
      chk($sformatf("v%0d_lead_space", i), runs[1], vecs[i].exp_space);
      if (vecs[i].rpt) begin
        chk($sformatf("v%0d_nruns", i), runs.size(), 3);
        if (runs.size() == 3) chk($sformatf("v%0d_stop", i), runs[2], 1125);
      end else begin
        chk($sformatf("v%0d_nruns", i), runs.size(), 67);
        if (runs.size() == 67) begin
          shape_bad = 0;
          bits = '0;
          for (int b = 0; b < 32; b++) begin
            if (runs[2 + 2 * b] != 1125) shape_bad++;
            if (runs[3 + 2 * b] == 3375) bits[b] = 1'b1;
            else if (runs[3 + 2 * b] != 1125) shape_bad++;
          end
          chk($sformatf("v%0d_bits", i), int'(bits), int'(vecs[i].exp_bits));
          chk($sformatf("v%0d_shape", i), shape_bad, 0);
          chk($sformatf("v%0d_stop", i), runs[66], 1125);
        end
      end
`endif
      @(negedge clk);
      chk($sformatf("v%0d_ready_after", i), o_ready, 1);
      chk($sformatf("v%0d_done_after", i), o_done, 0);
      chk($sformatf("v%0d_ir_after", i), o_ir, 0);
    end

    // Abort a frame with reset at its 5000th cycle
    @(negedge clk);
    i_valid = 1'b1; i_repeat = 1'b0; i_addr = 8'h5A; i_cmd = 8'h0F;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (4999) @(negedge clk);
    chk("abort_pre_busy", o_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ir", o_ir, 0);
    chk("abort_ready", o_ready, 1);
    chk("abort_done", o_done, 0);
    rst_n = 1'b1;
    quiet_bad = 0;
    repeat (3000) begin
      @(negedge clk);
      if (o_done !== 1'b0 || o_ir !== 1'b0 || o_ready !== 1'b1) quiet_bad++;
    end
    chk("abort_quiet", quiet_bad, 0);

    // i_valid held high: repeat codes back to back, one idle cycle between
    @(negedge clk);
    i_valid = 1'b1; i_repeat = 1'b1;
    dq.delete();
    rdy_cnt = 0; inv_bad = 0;
    for (int n = 1; n <= 70878; n++) begin
      @(negedge clk);
      if (o_busy === o_ready) inv_bad++;
      if (o_ready === 1'b1) rdy_cnt++;
      if (o_done === 1'b1) dq.push_back(n);
    end
    chk("b2b_frames", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("b2b_done0", dq[0], 23625);
      chk("b2b_done1", dq[1], 47251);
      chk("b2b_done2", dq[2], 70877);
    end
    chk("b2b_ready_cycles", rdy_cnt, 3);
    chk("b2b_busy_inv", inv_bad, 0);
    i_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("final_ready", o_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
